// File: rtl/fsm_sym_pkg.sv
// Shared symbol-line definitions for the 3-clock marker/data/stop framing,
// used by both the transmitter and the receive-side decoder.
package fsm_sym_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StData,
    StStop,
    StMark
  } sym_state_e;

  localparam int unsigned SYM_LEN  = 3;
  localparam logic        MARK_LVL = 1'b1;
  localparam logic        STOP_LVL = 1'b0;

endpackage

// File: rtl/fsm_sym_decoder_if.sv
// Serial line plus decoded-output bundle of the symbol decoder.
interface fsm_sym_decoder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             inp;
  logic             bit_out;
  logic             bit_valid;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             sym_err;
  logic             locked;

  modport master (
    output inp,
    input  bit_out,
    input  bit_valid,
    input  data_out,
    input  data_valid,
    input  sym_err,
    input  locked
  );

  modport slave (
    input  inp,
    output bit_out,
    output bit_valid,
    output data_out,
    output data_valid,
    output sym_err,
    output locked
  );

endinterface

// File: rtl/sym_word_deser.sv
// MSB-first word assembler: shifts accepted bits and publishes each full word
// with a one-cycle data_valid pulse.
module sym_word_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_i,
  input  logic             shift_en_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_valid_o
);

  localparam int unsigned     CntW   = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dv_q, dv_d;
  logic [WIDTH-1:0] word;

  assign word = {shreg_q[WIDTH-2:0], bit_i};

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    // A stale partial word is harmless: the counter restarts, so every
    // published word is fully overwritten by fresh bits.
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_en_i) begin
      shreg_d = word;
      if (cnt_q == CntMax) begin
        cnt_d  = '0;
        data_d = word;
        dv_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = dv_q;

endmodule

// File: rtl/fsm_sym_decoder.sv
// Receive-side decoder for the marker/data/stop symbol line: acquires
// alignment, flags framing errors, tracks lock and assembles words.
module fsm_sym_decoder
  import fsm_sym_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOCK_SYMS = 4
) (
  input logic                clk,
  input logic                reset,
  fsm_sym_decoder_if.slave   bus
);

  localparam int unsigned    GcW     = $clog2(LOCK_SYMS + 1);
  localparam logic [GcW-1:0] LockMax = GcW'(LOCK_SYMS);

  sym_state_e     state_q, state_d;
  logic           dbit_q, dbit_d;
  logic           bit_out_q, bit_out_d;
  logic           bit_valid_q;
  logic           sym_err_q;
  logic           locked_q, locked_d;
  logic [GcW-1:0] good_cnt_q, good_cnt_d;
  logic           good, err;

  always_comb begin
    state_d = state_q;
    dbit_d  = dbit_q;
    good    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StHunt: if (bus.inp == MARK_LVL) state_d = StData;
      StData: begin
        dbit_d  = bus.inp;
        state_d = StStop;
      end
      StStop: begin
        // A bad stop is dropped, not re-used as the next marker.
        if (bus.inp == STOP_LVL) begin
          good    = 1'b1;
          state_d = StMark;
        end else begin
          err     = 1'b1;
          state_d = StHunt;
        end
      end
      StMark: begin
        if (bus.inp == MARK_LVL) begin
          state_d = StData;
        end else begin
          err     = 1'b1;
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_comb begin
    good_cnt_d = good_cnt_q;
    if (err) begin
      good_cnt_d = '0;
    end else if (good && (good_cnt_q != LockMax)) begin
      good_cnt_d = good_cnt_q + 1'b1;
    end
    locked_d  = (good_cnt_d == LockMax);
    bit_out_d = good ? dbit_q : bit_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHunt;
      dbit_q      <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      sym_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      good_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dbit_q      <= dbit_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= good;
      sym_err_q   <= err;
      locked_q    <= locked_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

  // Only symbols arriving while already locked feed the word assembler.
  sym_word_deser #(
    .WIDTH (WIDTH)
  ) u_deser (
    .clk          (clk),
    .reset        (reset),
    .bit_i        (dbit_q),
    .shift_en_i   (good & locked_q),
    .clear_i      (err),
    .data_o       (bus.data_out),
    .data_valid_o (bus.data_valid)
  );

  assign bus.bit_out   = bit_out_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.sym_err   = sym_err_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_fsm_sym_decoder.sv
// Bench for fsm_sym_decoder: symbol-level reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_fsm_sym_decoder;

  localparam int unsigned W    = 8;
  localparam int unsigned LOCK = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  bit   cmp_en;

  fsm_sym_decoder_if #(.WIDTH(W)) bus ();

  fsm_sym_decoder #(
    .WIDTH     (W),
    .LOCK_SYMS (LOCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the expected symbol (-1 while hunting),
  // run of consecutive good symbols, and the bits collected for the current word.
  int         m_pos;
  int         m_run;
  logic       m_d;
  bit         m_locked;
  logic       m_q[$];
  logic       m_bv, m_bout, m_err, m_dv;
  logic [W-1:0] m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_err();
    m_err    = 1'b1;
    m_pos    = -1;
    m_run    = 0;
    m_locked = 1'b0;
    m_q.delete();
  endtask

  task automatic model_update(input logic in_v, input logic rst_v);
    logic [W-1:0] w;
    m_bv  = 1'b0;
    m_err = 1'b0;
    m_dv  = 1'b0;
    if (rst_v) begin
      m_pos    = -1;
      m_run    = 0;
      m_locked = 1'b0;
      m_q.delete();
      m_dout   = '0;
      m_bout   = 1'b0;
      return;
    end
    case (m_pos)
      -1: if (in_v) m_pos = 1;
      1: begin
        m_d   = in_v;
        m_pos = 2;
      end
      2: begin
        if (!in_v) begin
          m_bv   = 1'b1;
          m_bout = m_d;
          if (m_locked) m_q.push_back(m_d);
          m_run    = (m_run < LOCK) ? m_run + 1 : LOCK;
          m_locked = (m_run == LOCK);
          if (m_q.size() == W) begin
            w = '0;
            for (int i = 0; i < W; i++) w = {w[W-2:0], m_q[i]};
            m_dout = w;
            m_dv   = 1'b1;
            m_q.delete();
          end
          m_pos = 0;
        end else begin
          model_err();
        end
      end
      default: begin
        if (in_v) m_pos = 1;
        else model_err();
      end
    endcase
  endtask

  task automatic step(input logic in_v, input logic rst_v);
    bus.inp = in_v;
    reset   = rst_v;
    @(posedge clk);
    model_update(in_v, rst_v);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    step(1'b1, 1'b0);
    step(b, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("bit_valid", {31'b0, bus.bit_valid}, {31'b0, m_bv});
      if (m_bv) chk("bit_out", {31'b0, bus.bit_out}, {31'b0, m_bout});
      chk("sym_err", {31'b0, bus.sym_err}, {31'b0, m_err});
      chk("locked", {31'b0, bus.locked}, {31'b0, m_locked});
      chk("data_valid", {31'b0, bus.data_valid}, {31'b0, m_dv});
      chk("data_out", 32'(bus.data_out), 32'(m_dout));
    end
  end

  initial begin
    logic bits[60];
    int   n_err;
    int   n_dv;
    bit   seen_lock;
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 1'b0;
    bus.inp  = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b1);
    cmp_en = 1'b1;

    // Idle line after reset
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("idle_locked", {31'b0, bus.locked}, 32'd0);
    chk("idle_data_out", 32'(bus.data_out), 32'd0);

    // Acquire lock with four ones
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("lock_bv", {31'b0, bus.bit_valid}, 32'd1);
    chk("lock_rise", {31'b0, bus.locked}, 32'd1);

    send_word(8'hA5);
    chk("a5_dv", {31'b0, bus.data_valid}, 32'd1);
    chk("a5_data", 32'(bus.data_out), 32'hA5);

    // Framing error three bits into a word
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("err_pulse", {31'b0, bus.sym_err}, 32'd1);
    chk("err_unlock", {31'b0, bus.locked}, 32'd0);
    chk("err_no_dv", {31'b0, bus.data_valid}, 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    send_word(8'h3C);
    chk("3c_data", 32'(bus.data_out), 32'h3C);

    // Start mid-symbol into a random stream
    for (int off = 1; off <= 2; off++) begin
      step(1'b0, 1'b1);
      for (int i = 0; i < 60; i++) bits[i] = 1'($urandom_range(0, 1));
      bits[1]   = 1'b0;
      n_err     = 0;
      n_dv      = 0;
      seen_lock = 1'b0;
      for (int k = off; k < 180; k++) begin
        case (k % 3)
          0:       step(1'b1, 1'b0);
          1:       step(bits[k / 3], 1'b0);
          default: step(1'b0, 1'b0);
        endcase
        if (!seen_lock && bus.sym_err) n_err++;
        if (bus.locked) seen_lock = 1'b1;
        if (bus.data_valid) n_dv++;
      end
      chk("phase_errs_le2", {31'b0, n_err <= 2}, 32'd1);
      chk("phase_locked", {31'b0, seen_lock}, 32'd1);
      chk("phase_words", {31'b0, n_dv >= 5}, 32'd1);
    end

    // Reset during the data sample of the 5th bit of a word
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_locked", {31'b0, bus.locked}, 32'd0);
    chk("rst_bv", {31'b0, bus.bit_valid}, 32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_word(8'hFF);
    chk("ff_dv", {31'b0, bus.data_valid}, 32'd1);
    chk("ff_data", 32'(bus.data_out), 32'hFF);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
